branch_hazard_ctl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. Resolves taken branches from MEM-stage branch control and ALU zero, drives the PC-source select and IF/ID, ID/EX, EX/MEM flushes, and inserts one-cycle load-use stalls. It also keeps saturating performance counters for taken branches and stall cycles. It replaces the bare branch AND gate between the EX/MEM register and the PC mux.

---
 rtl/pipe_ctl_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/branch_hazard_ctl.sv | 119 +++++++++++
 tb/tb_branch_hazard_ctl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctl_pkg;

   // Default register-specifier width for the 32-register MIPS file.
   localparam int REG_ADDR_W_DEFAULT = 5;

   // Control state encoding.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
// Latency: the count reflects an inc one cycle after it is asserted.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (sync, active-high, clears to 0), inc (count enable),
//        count (current value).
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/branch_hazard_ctl.sv
// Pipeline control: taken-branch redirect/flush, one-cycle load-use stall,
// and saturating counters for taken branches and stall cycles.
// Latency: control outputs are combinational (same cycle); counters lag by 1.
// Backpressure: drives pipeline backpressure via pc_write/ifid_write/idex_bubble.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m_branch, m_zero          branch control and ALU zero from EX/MEM
//   ex_memread, ex_rt         load in EX and its destination register
//   id_rs, id_rt, id_uses_rt  source registers of the instruction in ID
//   pcsrc, pc_write           PC mux select and PC load enable
//   ifid_write, idex_bubble   IF/ID load enable, zero ID/EX control fields
//   ifid_flush, idex_flush, exmem_flush   pipeline register clears
//   taken_cnt, stall_cnt      saturating performance counters
module branch_hazard_ctl
   import pipe_ctl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m_branch,
   input  logic                  m_zero,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   output logic                  pcsrc,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic [CNT_W-1:0]      taken_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   ctl_state_t state, state_nxt;
   logic       taken;
   logic       hazard;
   logic       inc_taken;
   logic       inc_stall;

   assign taken  = m_branch & m_zero;

   // Register 0 is hardwired to zero, so a load "to" it can never feed ID.
   assign hazard = ex_memread & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   always_comb begin
      pcsrc       = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      inc_taken   = 1'b0;
      inc_stall   = 1'b0;
      state_nxt   = ST_RUN;

      if (rst) begin
         // Freeze the front end while reset is held.
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else begin
         case (state)
            ST_RUN, ST_STALL: begin
               if (taken) begin
                  // Redirect wins over a coincident load-use: the stalled
                  // instruction is on the wrong path and gets flushed anyway.
                  pcsrc       = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  inc_taken   = 1'b1;
                  state_nxt   = ST_FLUSH;
               end else if (hazard && (state == ST_RUN)) begin
                  // In STALL the load has moved to MEM; forwarding covers it,
                  // so a lingering match must not stall a second time.
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  inc_stall   = 1'b1;
                  state_nxt   = ST_STALL;
               end
            end
            // FLUSH: EX/MEM still shows the redirected branch this cycle, so
            // taken/hazard are stale and ignored; normal advance.
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_taken),
      .count (taken_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_stall),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_branch_hazard_ctl.sv
// Bench for branch_hazard_ctl: directed scenarios plus random traffic,
// checked against a behavioural model through an expected-value queue.
// Two DUTs share inputs: 16-bit counters and 2-bit counters (saturation).
module tb_branch_hazard_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       m_branch, m_zero, ex_memread, id_uses_rt;
   logic [4:0] ex_rt, id_rs, id_rt;

   logic        pcsrc, pc_write, ifid_write, idex_bubble;
   logic        ifid_flush, idex_flush, exmem_flush;
   logic [15:0] taken_cnt, stall_cnt;

   logic        s_pcsrc, s_pc_write, s_ifid_write, s_idex_bubble;
   logic        s_ifid_flush, s_idex_flush, s_exmem_flush;
   logic [1:0]  s_taken_cnt, s_stall_cnt;

   always #5 clk = ~clk;

   branch_hazard_ctl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .m_branch(m_branch), .m_zero(m_zero),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .pcsrc(pcsrc), .pc_write(pc_write),
      .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   branch_hazard_ctl #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .m_branch(m_branch), .m_zero(m_zero),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .pcsrc(s_pcsrc), .pc_write(s_pc_write),
      .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .exmem_flush(s_exmem_flush), .taken_cnt(s_taken_cnt),
      .stall_cnt(s_stall_cnt)
   );

   typedef struct {
      logic [6:0] ctl;   // pcsrc,pc_write,ifid_write,bubble,ifid_f,idex_f,exmem_f
      int         tc;
      int         sc;
      int         tc2;
      int         sc2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Model state: what happened in the previous cycle, plus counter values.
   bit   prev_redirect = 0;
   bit   prev_stalled  = 0;
   int   m_tc = 0, m_sc = 0, m_tc2 = 0, m_sc2 = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are valid every cycle; sample mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("ctl",       int'({pcsrc, pc_write, ifid_write, idex_bubble,
                                ifid_flush, idex_flush, exmem_flush}), int'(e.ctl));
         chk("ctl_sat",   int'({s_pcsrc, s_pc_write, s_ifid_write, s_idex_bubble,
                                s_ifid_flush, s_idex_flush, s_exmem_flush}), int'(e.ctl));
         chk("taken_cnt", int'(taken_cnt),   e.tc);
         chk("stall_cnt", int'(stall_cnt),   e.sc);
         chk("taken_sat", int'(s_taken_cnt), e.tc2);
         chk("stall_sat", int'(s_stall_cnt), e.sc2);
      end
   end

   function automatic int sat_inc(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   // Drive one cycle of inputs, push the model's expectation, advance model.
   task automatic step(input logic r, input logic b, input logic z,
                       input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt);
      exp_t e;
      bit   tk, hz, redirect, stall;
      @(posedge clk);
      #1;
      rst = r; m_branch = b; m_zero = z; ex_memread = mr;
      ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;

      tk = b && z;
      hz = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
      redirect = !r && !prev_redirect && tk;
      stall    = !r && !prev_redirect && !tk && !prev_stalled && hz;

      e.tc = m_tc; e.sc = m_sc; e.tc2 = m_tc2; e.sc2 = m_sc2;
      if (r)             e.ctl = 7'b0000000;
      else if (redirect) e.ctl = 7'b1110111;
      else if (stall)    e.ctl = 7'b0001000;
      else               e.ctl = 7'b0110000;
      exp_q.push_back(e);

      if (r) begin
         m_tc = 0; m_sc = 0; m_tc2 = 0; m_sc2 = 0;
         prev_redirect = 0; prev_stalled = 0;
      end else begin
         if (redirect) begin
            m_tc  = sat_inc(m_tc, 65535);
            m_tc2 = sat_inc(m_tc2, 3);
         end
         if (stall) begin
            m_sc  = sat_inc(m_sc, 65535);
            m_sc2 = sat_inc(m_sc2, 3);
         end
         prev_redirect = redirect;
         prev_stalled  = stall;
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      int sat_seq[5];
      sat_seq = '{1, 2, 3, 3, 3};
      rst = 1'b1; m_branch = 0; m_zero = 0; ex_memread = 0;
      ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;

      // Reset and idle release.
      do_reset(3);
      idle(); idle();

      // Load-use held two cycles: stall then normal advance.
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0);
      idle();

      // Taken branch held two cycles: redirect then masked FLUSH cycle.
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle();

      // Taken plus rt load-use in the same cycle.
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd2, 5'd5, 1'b1);
      idle();

      // Register zero and rt gating: neither may stall.
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 5'd3, 1'b0);
      idle();

      // Reset mid-STALL and mid-FLUSH.
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      do_reset(1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      do_reset(1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

      // Saturation on the 2-bit instance: 5 taken branches, idle between.
      do_reset(2);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         idle();
         #1;
         chk("sat_seq", int'(s_taken_cnt), sat_seq[k]);
      end

      // Random traffic on a small register range so matches are common.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 150) == 0,
              ($urandom % 3) == 0,
              ($urandom % 2) == 1,
              ($urandom % 2) == 1,
              5'($urandom % 4),
              5'($urandom % 4),
              5'($urandom % 4),
              ($urandom % 2) == 1);
      end

      idle();
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
